// File: rtl/vga_pkg.sv
// Shared VGA-subsystem types: the pending VRAM write entry that the MPU side
// hands to the MemoryManager through the pending-write FIFO.
package vga_pkg;

  localparam int PW_ADDR_WIDTH = 17;
  localparam int PW_DATA_WIDTH = 8;
  localparam int PW_WIDTH      = PW_ADDR_WIDTH + PW_DATA_WIDTH;

  typedef struct packed {
    logic [PW_ADDR_WIDTH-1:0] address;
    logic [PW_DATA_WIDTH-1:0] data;
  } pending_write_t;

endpackage

// File: rtl/fifo_storage.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module fifo_storage #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                     clock,
  input  logic                     writeEnable,
  input  logic [$clog2(DEPTH)-1:0] writeAddress,
  input  logic [WIDTH-1:0]         writeData,
  input  logic [$clog2(DEPTH)-1:0] readAddress,
  output logic [WIDTH-1:0]         readData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clock) begin
    if (writeEnable) begin
      mem[writeAddress] <= writeData;
    end
  end

  // Distributed-RAM style read, no output register
  assign readData = mem[readAddress];

endmodule

// File: rtl/pending_write_fifo.sv
// Show-ahead FIFO buffering MPU VRAM writes until MemoryManager has a free
// RAM slot; pointers, level and sticky debug flags live here.
module pending_write_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WIDTH       = PW_WIDTH,
  parameter int ALMOST_FULL = 12
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   clear,
  input  logic                   writeRequest,
  input  logic [WIDTH-1:0]       writeBus,
  output logic                   full,
  output logic                   almostFull,
  input  logic                   readRequest,
  output logic [WIDTH-1:0]       readBus,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtrNext;
  logic [PTR_W-1:0] rdPtrNext;
  logic [LVL_W-1:0] levelNext;
  logic             pushAcc;
  logic             popAcc;
  logic             overflowNext;
  logic             underflowNext;
  logic [WIDTH-1:0] storageData;

  fifo_storage #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) storage (
    .clock        (clock),
    .writeEnable  (pushAcc & ~clear),
    .writeAddress (wrPtr),
    .writeData    (writeBus),
    .readAddress  (rdPtr),
    .readData     (storageData)
  );

  // A push into a full FIFO is still taken when the head is popped the same cycle
  always_comb begin
    pushAcc = writeRequest && (!full || readRequest);
    popAcc  = readRequest && !empty;
  end

  // Next pointers, level and sticky flags
  always_comb begin
    wrPtrNext     = wrPtr;
    rdPtrNext     = rdPtr;
    levelNext     = level;
    overflowNext  = overflow  | (writeRequest && full && !readRequest);
    underflowNext = underflow | (readRequest && empty);
    if (pushAcc) begin
      wrPtrNext = wrPtr + PTR_W'(1);
    end else begin
      wrPtrNext = wrPtr;
    end
    if (popAcc) begin
      rdPtrNext = rdPtr + PTR_W'(1);
    end else begin
      rdPtrNext = rdPtr;
    end
    if (pushAcc && !popAcc) begin
      levelNext = level + LVL_W'(1);
    end else if (popAcc && !pushAcc) begin
      levelNext = level - LVL_W'(1);
    end else begin
      levelNext = level;
    end
  end

  // Control state; clear acts as a synchronous copy of reset
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr      <= {PTR_W{1'b0}};
      rdPtr      <= {PTR_W{1'b0}};
      level      <= {LVL_W{1'b0}};
      empty      <= 1'b1;
      full       <= 1'b0;
      almostFull <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (clear) begin
      wrPtr      <= {PTR_W{1'b0}};
      rdPtr      <= {PTR_W{1'b0}};
      level      <= {LVL_W{1'b0}};
      empty      <= 1'b1;
      full       <= 1'b0;
      almostFull <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      wrPtr      <= wrPtrNext;
      rdPtr      <= rdPtrNext;
      level      <= levelNext;
      empty      <= (levelNext == {LVL_W{1'b0}});
      full       <= (levelNext == LVL_W'(DEPTH));
      almostFull <= (levelNext >= LVL_W'(ALMOST_FULL));
      overflow   <= overflowNext;
      underflow  <= underflowNext;
    end
  end

  // Storage is never reset, so mask the head while nothing is held
  always_comb begin
    readBus = {WIDTH{1'b0}};
    if (!empty) begin
      readBus = storageData;
    end else begin
      readBus = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_pending_write_fifo.sv
// Directed and randomized bench for pending_write_fifo against a queue model.
module tb_pending_write_fifo;
  import vga_pkg::*;

  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic        clock;
  logic        resetN;
  logic        clear;
  logic        writeRequest;
  logic [24:0] writeBus;
  logic        full;
  logic        almostFull;
  logic        readRequest;
  logic [24:0] readBus;
  logic        empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  logic [24:0] modelQ[$];
  logic        modelOvf;
  logic        modelUnf;

  pending_write_fifo #(
    .DEPTH       (DEPTH),
    .WIDTH       (25),
    .ALMOST_FULL (AF)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .clear        (clear),
    .writeRequest (writeRequest),
    .writeBus     (writeBus),
    .full         (full),
    .almostFull   (almostFull),
    .readRequest  (readRequest),
    .readBus      (readBus),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int n;
    n = modelQ.size();
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".almostFull"}, 32'(almostFull), 32'(n >= AF));
    check({tag, ".overflow"}, 32'(overflow), 32'(modelOvf));
    check({tag, ".underflow"}, 32'(underflow), 32'(modelUnf));
    check({tag, ".readBus"}, 32'(readBus), (n == 0) ? 32'd0 : 32'(modelQ[0]));
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf = 1'b0;
    modelUnf = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge
  task automatic step(input string tag, input logic wr, input logic [24:0] d,
                      input logic rd, input logic clr);
    bit canPush;
    bit canPop;
    writeRequest = wr;
    writeBus     = d;
    readRequest  = rd;
    clear        = clr;
    @(posedge clock);
    if (clr) begin
      modelReset();
    end else begin
      canPush = wr && (modelQ.size() < DEPTH || rd);
      canPop  = rd && (modelQ.size() > 0);
      if (wr && modelQ.size() == DEPTH && !rd) modelOvf = 1'b1;
      if (rd && modelQ.size() == 0) modelUnf = 1'b1;
      if (canPop) void'(modelQ.pop_front());
      if (canPush) modelQ.push_back(d);
    end
    @(negedge clock);
    writeRequest = 1'b0;
    readRequest  = 1'b0;
    clear        = 1'b0;
    checkAll(tag);
  endtask

  initial begin
    pending_write_t pw;
    resetN       = 1'b0;
    clear        = 1'b0;
    writeRequest = 1'b0;
    readRequest  = 1'b0;
    writeBus     = 25'd0;
    modelReset();

    repeat (3) @(negedge clock);
    checkAll("reset");
    resetN = 1'b1;
    @(negedge clock);
    checkAll("afterRelease");

    pw.address = 17'h01234;
    pw.data    = 8'hA5;
    step("singlePush", 1'b1, pw, 1'b0, 1'b0);
    check("singlePush.constant", 32'(readBus), 32'h01234A5);
    step("singlePop", 1'b0, 25'd0, 1'b1, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      pw.address = 17'(17'h100 + i);
      pw.data    = 8'(i);
      step("fill", 1'b1, pw, 1'b0, 1'b0);
    end
    check("fill.fullFlag", 32'(full), 32'd1);

    pw.address = 17'h1FFFF;
    pw.data    = 8'hEE;
    step("fullPushPop", 1'b1, pw, 1'b1, 1'b0);
    step("fullPushOnly", 1'b1, 25'h0ABCDE, 1'b0, 1'b0);
    check("overflow.set", 32'(overflow), 32'd1);

    for (int i = 0; i < DEPTH; i++) begin
      step("drain", 1'b0, 25'd0, 1'b1, 1'b0);
    end
    step("popEmpty", 1'b0, 25'd0, 1'b1, 1'b0);
    step("emptyPushPop", 1'b1, 25'h0055AA, 1'b1, 1'b0);
    step("clearWithReq", 1'b1, 25'h000777, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) begin
      step("prePush", 1'b1, 25'(32'h200 + i), 1'b0, 1'b0);
    end
    #2;
    resetN = 1'b0;
    modelReset();
    #1;
    checkAll("midReset");
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    step("postResetPush", 1'b1, 25'h1ACE00, 1'b0, 1'b0);

    // Random traffic, biased in phases so both full and empty are reached
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 60) % 2 == 0) ? 75 : 25;
      step("random", ($urandom_range(0, 99) < wp), 25'($urandom),
           ($urandom_range(0, 99) < (100 - wp)), ($urandom_range(0, 199) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
